eth_header_parser: RTL
======================

Name: eth_header_parser

Overview:
- Receive-side counterpart of the Ethernet header generator.
- Consumes a byte-serial Ethernet frame stream (no preamble/SFD/FCS) and extracts the 14-byte header: destination MAC, source MAC, type/length.
- Converts header fields from wire (network) byte order to host-order vectors.
- Forwards the payload bytes on a registered valid/ready stream, with an optional destination-MAC filter.

Parameters:
- LOCAL_MAC, 48'he86a64e7e829, station address accepted by the filter.
- PACKET_PAYLOAD_BYTES, 128, expected payload length in bytes; used for the length check.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- s_data  in  8  input frame byte, wire order.
- s_valid  in  1  s_data valid.
- s_last  in  1  marks the final byte of a frame.
- s_ready  out  1  parser accepts the byte this cycle.
- m_data  out  8  payload byte.
- m_valid  out  1  m_data valid.
- m_last  out  1  final payload byte of the frame.
- m_ready  in  1  downstream accepts the payload byte.
- mac_destination  out  48  parsed destination MAC; first wire byte at [47:40].
- mac_source  out  48  parsed source MAC; first wire byte at [47:40].
- eth_type_length  out  16  parsed type/length; first wire byte at [15:8].
- hdr_valid  out  1  one-cycle pulse: header fields updated for an accepted frame.
- frame_done  out  1  one-cycle pulse at the end of any frame.
- len_err  out  1  qualified by frame_done: payload count mismatch.
- runt_err  out  1  qualified by frame_done: s_last arrived inside the header.

Behaviour:
- Handshake: a byte is accepted when s_valid && s_ready. A payload byte transfers when m_valid && m_ready.
- Reset: state=HEADER, byte counter=0, payload count=0. Every output is 0 (m_valid, m_last, m_data, header fields, hdr_valid, frame_done, len_err, runt_err). s_ready follows the state rules below.
- State HEADER:
  - s_ready=1.
  - Byte index 0..13 is shifted into a header shadow register: bytes 0-5 dest, 6-11 src, 12-13 type/length, MSB-first.
  - On accepting byte 13 without s_last: copy shadow to the output fields, pulse hdr_valid the next cycle, go to PAYLOAD (or DROP if filtered).
  - Byte 13 with s_last: header is valid and payload is empty. Update the fields, pulse hdr_valid and frame_done, go to HEADER; len_err is evaluated with count 0.
  - s_last on byte index <13: pulse frame_done with runt_err=1, leave the output fields unchanged, no hdr_valid, return to HEADER index 0.
- State PAYLOAD:
  - One-entry output register; s_ready = !m_valid || m_ready.
  - Accepted byte loads m_data, m_valid=1, m_last=s_last.
  - Payload count is 16-bit and saturates at 16'hFFFF.
  - On accepting s_last: go to HEADER; frame_done pulses the same cycle the last byte loads.
  - len_err=1 iff eth_type_length <= 1500 and the final count != eth_type_length, or the final count != PACKET_PAYLOAD_BYTES. Type values >= 1536 are EtherTypes: only the PACKET_PAYLOAD_BYTES check applies.
- State DROP:
  - s_ready=1; bytes are discarded and m_valid is not raised.
  - On s_last: frame_done pulses with len_err=0 and runt_err=0, then go to HEADER.
- Output register: the next frame's header parsing may proceed while the last payload byte is still held in m_data/m_valid. m_valid clears on m_ready.
- Simultaneous m_ready and new accept in PAYLOAD: the register reloads the new byte, giving one byte per cycle with no bubble.
- Latency: payload byte appears on m_data one cycle after acceptance. hdr_valid is one cycle after byte 13 is accepted.
- Reset mid-frame: the frame is abandoned with no frame_done, and the first accepted byte after reset is byte 0 of a new frame.

Optional Feature:
- Macro: ETH_MAC_FILTER_EN.
- Defined: after byte 13, a frame whose destination is neither LOCAL_MAC nor 48'hFFFFFFFFFFFF enters DROP. No hdr_valid, header outputs are not updated.
- Undefined: every complete header is accepted and DROP is unreachable.

Test Plan:
- Nominal frame: dest e86a64e7e829, src e86a64e7e830, type/length 16'h0080, 128 payload bytes 0x00..0x7F, m_ready=1. Expect hdr_valid with fields matching, 128 bytes out in order, m_last on 0x7F, frame_done with len_err=0.
- Backpressure: same frame with m_ready toggling 1,0,0,1 each cycle. Expect no byte lost or duplicated, and s_ready low exactly while m_valid && !m_ready.
- Runt: s_last on byte index 9. Expect frame_done with runt_err=1, no hdr_valid, outputs unchanged; the next frame parses correctly.
- Length mismatch: type/length 16'h0080 but 100 payload bytes. Expect frame_done with len_err=1 and m_last on the 100th byte.
- Filter with ETH_MAC_FILTER_EN: dest 112233445566 is dropped (no m_valid, frame_done only); broadcast dest is accepted. Without the macro, both are accepted.
- Reset pulse at payload byte 50: all outputs 0 the next cycle; the following frame is parsed from byte 0 with correct fields.

Source files
------------

// File: rtl/eth_header_parser.sv
// eth_header_parser
//   Receive-side Ethernet header parser. Consumes a byte-serial frame (no
//   preamble/SFD/FCS) and extracts the 14-byte header into host-order fields.
//   Payload bytes leave through a one-entry registered valid/ready stage.
//
//   Optional build macro ETH_MAC_FILTER_EN: when defined, frames whose
//   destination is neither LOCAL_MAC nor broadcast are dropped.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   s_data/s_valid/s_last/s_ready   input frame stream (wire byte order)
//   m_data/m_valid/m_last/m_ready   output payload stream
//   mac_destination, mac_source, eth_type_length   parsed header fields
//   hdr_valid          pulse: header fields updated for an accepted frame
//   frame_done         pulse: end of any frame
//   len_err, runt_err  status, qualified by frame_done

module eth_header_parser #(
  parameter logic [47:0] LOCAL_MAC            = 48'he86a64e7e829,
  parameter int unsigned PACKET_PAYLOAD_BYTES = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic [47:0] mac_destination,
  output logic [47:0] mac_source,
  output logic [15:0] eth_type_length,
  output logic        hdr_valid,
  output logic        frame_done,
  output logic        len_err,
  output logic        runt_err
);

`ifdef ETH_MAC_FILTER_EN
  localparam bit FilterEn = 1'b1;
`else
  localparam bit FilterEn = 1'b0;
`endif

  localparam logic [15:0] ExpLen    = PACKET_PAYLOAD_BYTES[15:0];
  localparam logic [3:0]  LastHdrIdx = 4'd13;

  typedef enum logic [1:0] {StHeader, StPayload, StDrop} state_e;

  state_e        state_q, state_d;
  logic [3:0]    byte_idx_q, byte_idx_d;
  logic [103:0]  shadow_q, shadow_d;     // header bytes 0..12, byte 0 at the top
  logic [15:0]   pay_cnt_q, pay_cnt_d;
  logic [7:0]    m_data_q, m_data_d;
  logic          m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d;
  logic [47:0]   dest_q, dest_d;
  logic [47:0]   src_q, src_d;
  logic [15:0]   type_q, type_d;
  logic          hdr_valid_q, hdr_valid_d;
  logic          frame_done_q, frame_done_d;
  logic          len_err_q, len_err_d;
  logic          runt_err_q, runt_err_d;

  logic          accept;
  logic          hdr_done;
  logic [111:0]  hdr_full;
  logic          dest_ok;
  logic          hdr_keep;
  logic [15:0]   pay_cnt_inc;

  // Length/type rule: lengths (<= 1500) must match the count; every frame
  // must also carry the configured payload size.
  function automatic logic len_mismatch(input logic [15:0] count, input logic [15:0] type_len);
    return ((type_len <= 16'd1500) && (count != type_len)) || (count != ExpLen);
  endfunction

  assign accept   = s_valid && s_ready;
  assign hdr_done = (byte_idx_q == LastHdrIdx);
  // Full header as it stands once byte 13 is on s_data.
  assign hdr_full = {shadow_q, s_data};
  assign dest_ok  = (hdr_full[111:64] == LOCAL_MAC) || (hdr_full[111:64] == 48'hFFFFFFFFFFFF);
  assign hdr_keep = !FilterEn || dest_ok;
  assign pay_cnt_inc = (pay_cnt_q == 16'hFFFF) ? pay_cnt_q : pay_cnt_q + 16'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StHeader;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHeader: begin
        if (accept && hdr_done && !s_last) begin
          state_d = hdr_keep ? StPayload : StDrop;
        end
      end
      StPayload, StDrop: begin
        if (accept && s_last) begin
          state_d = StHeader;
        end
      end
      default: state_d = StHeader;
    endcase
  end

  // FSM outputs: only the payload state can stall on the output register.
  always_comb begin
    s_ready = 1'b1;
    if (state_q == StPayload) begin
      s_ready = !m_valid_q || m_ready;
    end
  end

  // Datapath next-state.
  always_comb begin
    byte_idx_d   = byte_idx_q;
    shadow_d     = shadow_q;
    pay_cnt_d    = pay_cnt_q;
    m_data_d     = m_data_q;
    m_valid_d    = m_valid_q;
    m_last_d     = m_last_q;
    dest_d       = dest_q;
    src_d        = src_q;
    type_d       = type_q;
    hdr_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    len_err_d    = 1'b0;
    runt_err_d   = 1'b0;

    // Held byte drains independently of the input side, so the next header
    // can be parsed while the previous frame's last byte is still waiting.
    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    unique case (state_q)
      StHeader: begin
        if (accept) begin
          shadow_d = {shadow_q[95:0], s_data};
          if (hdr_done) begin
            byte_idx_d = 4'd0;
            pay_cnt_d  = 16'd0;
            if (hdr_keep) begin
              dest_d      = hdr_full[111:64];
              src_d       = hdr_full[63:16];
              type_d      = hdr_full[15:0];
              hdr_valid_d = 1'b1;
            end
            if (s_last) begin
              frame_done_d = 1'b1;
              len_err_d    = hdr_keep && len_mismatch(16'd0, hdr_full[15:0]);
            end
          end else if (s_last) begin
            byte_idx_d   = 4'd0;
            frame_done_d = 1'b1;
            runt_err_d   = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 4'd1;
          end
        end
      end
      StPayload: begin
        if (accept) begin
          m_data_d  = s_data;
          m_valid_d = 1'b1;
          m_last_d  = s_last;
          pay_cnt_d = pay_cnt_inc;
          if (s_last) begin
            frame_done_d = 1'b1;
            len_err_d    = len_mismatch(pay_cnt_inc, type_q);
          end
        end
      end
      StDrop: begin
        if (accept && s_last) begin
          frame_done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx_q   <= 4'd0;
      shadow_q     <= '0;
      pay_cnt_q    <= 16'd0;
      m_data_q     <= 8'd0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      dest_q       <= 48'd0;
      src_q        <= 48'd0;
      type_q       <= 16'd0;
      hdr_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      len_err_q    <= 1'b0;
      runt_err_q   <= 1'b0;
    end else begin
      byte_idx_q   <= byte_idx_d;
      shadow_q     <= shadow_d;
      pay_cnt_q    <= pay_cnt_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      dest_q       <= dest_d;
      src_q        <= src_d;
      type_q       <= type_d;
      hdr_valid_q  <= hdr_valid_d;
      frame_done_q <= frame_done_d;
      len_err_q    <= len_err_d;
      runt_err_q   <= runt_err_d;
    end
  end

  assign m_data          = m_data_q;
  assign m_valid         = m_valid_q;
  assign m_last          = m_last_q;
  assign mac_destination = dest_q;
  assign mac_source      = src_q;
  assign eth_type_length = type_q;
  assign hdr_valid       = hdr_valid_q;
  assign frame_done      = frame_done_q;
  assign len_err         = len_err_q;
  assign runt_err        = runt_err_q;

endmodule
